note_sequencer: RTL and testbench
=================================

Name: note_sequencer

Overview:
- Score scheduler for the music player.
- Steps through an external note-score ROM and presents the current note as three BCD digits (high, med, low) to the tone generator and the note-indicator LED block.
- Holds each note for a programmed number of beats.
- Supports start, pause, stop, looping and end-of-score detection.

Parameters:
- CLK_HZ, 50000000, system clock frequency in Hz.
- BEAT_HZ, 4, beat rate in Hz. The divider terminal count is CLK_HZ/BEAT_HZ-1, and CLK_HZ/BEAT_HZ must be at least 2.
- ADDR_W, 8, score ROM address width. The score length is 2**ADDR_W entries.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; starts playback from address 0.
- stop  in  1  one-cycle pulse; aborts playback and returns to idle.
- pause  in  1  level; freezes playback while high.
- loop_en  in  1  level; wrap to address 0 at score end instead of finishing.
- rom_addr  out  ADDR_W  score ROM address.
- rom_en  out  1  score ROM read enable.
- rom_data  in  16  score entry {dur[3:0], high[3:0], med[3:0], low[3:0]}. Data is valid one cycle after rom_en.
- high  out  4  current note, high-octave digit.
- med  out  4  current note, middle-octave digit.
- low  out  4  current note, low-octave digit.
- note_strobe  out  1  one-cycle pulse when a new note is loaded.
- busy  out  1  high in FETCH, LOAD, PLAY and PAUSED.
- done  out  1  high in DONE.

Behaviour:
- Reset values: rom_addr=0, rom_en=0, high/med/low=0 (silence), note_strobe=0, busy=0, done=0. State is IDLE, beat counter is 0, beats_left is 0.
- States are IDLE, FETCH, LOAD, PLAY, PAUSED, DONE.
- IDLE:
  - Outputs silence.
  - start -> rom_addr=0, go to FETCH.
- FETCH:
  - rom_en=1 for exactly this one cycle at the current rom_addr.
  - Go to LOAD.
- LOAD:
  - Capture rom_data.
  - If dur==0, the entry is an end marker: go to DONE, or if loop_en=1, set rom_addr=0 and go to FETCH. If the marker is at address 0 and loop_en=1, the block re-fetches indefinitely; this is acceptable.
  - Otherwise: load high/med/low from the entry, beats_left=dur, clear the beat counter, pulse note_strobe, go to PLAY.
- PLAY:
  - The beat counter increments each cycle and produces tick at the terminal count, then wraps to 0.
  - On tick with beats_left>1, beats_left decrements.
  - On tick with beats_left==1, advance to the next entry:
    - If rom_addr==2**ADDR_W-1: with loop_en=1, rom_addr=0 and go to FETCH; otherwise go to DONE.
    - Otherwise rom_addr increments and the block goes to FETCH.
  - The previous note stays on high/med/low through FETCH/LOAD, so there is no silence gap between notes.
  - New note latency is 2 cycles after the final tick.
  - Note duration is exactly dur*CLK_HZ/BEAT_HZ cycles, measured between note_strobe pulses.
- PAUSED:
  - Entered from PLAY when pause=1. The check happens before the tick, so pause wins over a coincident tick.
  - Beat counter and beats_left are frozen. high/med/low output 0 (muted); the internal note register is retained.
  - pause=0 -> return to PLAY; the stored note is restored the next cycle.
  - pause has no effect in IDLE, FETCH, LOAD or DONE. If pause is high when FETCH/LOAD completes, the block enters PLAY and then PAUSED the cycle after.
- DONE:
  - Outputs silence, done=1, and holds.
  - start -> rom_addr=0, go to FETCH, done drops.
- stop:
  - In any state, the next cycle is IDLE with silence and rom_addr=0. The beat counter and beats_left are cleared.
  - stop beats a coincident start.
- start while busy is ignored.
- Reset asserted mid-note forces all reset values immediately (asynchronous). Playback does not resume after reset is released.
- Digits pass through unmodified, including non-BCD values. This block does not validate digits.

Decomposition:
- Shared package note_pkg holds:
  - State encoding constants: IDLE=0, FETCH=1, LOAD=2, PLAY=3, PAUSED=4, DONE=5; 3-bit state.
  - Score field slice positions: DUR 15:12, HIGH 11:8, MED 7:4, LOW 3:0.
  - The SILENCE=12'h000 constant.
- One sub-module, beat_tick_gen, holds the parameterised divider with inputs clk, rst_n, run and clear, and output tick.

Test Plan:
All scenarios use CLK_HZ=40, BEAT_HZ=4 (10 cycles per beat), ADDR_W=3.
- Basic: ROM {2,0,0,3},{1,0,2,0},{0,x,x,x}, pulse start.
  - note_strobe fires 2 cycles after start with outputs 003.
  - 020 follows 20 cycles later.
  - done=1 with outputs 000 10 cycles after that.
- Pause: pause=1 for 15 cycles mid-note of a 3-beat note -> outputs 000 while paused. Total note duration is 30+15 cycles, and the note value is restored after pause.
- Loop: loop_en=1, ROM {1,1,0,0},{0,...} -> note 100 re-strobes every 12 cycles (10 beat + 2 fetch). done is never asserted.
- Full wrap: all 8 entries dur=1 with loop_en=0 -> after address 7, the block goes to DONE with no fetch at address 0. With loop_en=1, the next rom_addr is 0.
- Stop/start priority:
  - stop and start asserted in the same cycle during PLAY -> IDLE, outputs 000, rom_addr=0, busy=0.
  - start alone during PLAY -> ignored; the current note continues.
- Async reset: assert rst_n=0 mid-note between clock edges -> outputs 000, busy=0, done=0 before the next edge, and the block stays in IDLE after release.

Source files
------------

// File: rtl/note_pkg.sv
// Shared definitions for the note sequencer: state encoding, score-entry
// field positions and small helpers for unpacking a score entry.
package note_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    LOAD   = 3'd2,
    PLAY   = 3'd3,
    PAUSED = 3'd4,
    DONE   = 3'd5
  } state_t;

  localparam int DUR_HI  = 15;
  localparam int DUR_LO  = 12;
  localparam int HIGH_HI = 11;
  localparam int HIGH_LO = 8;
  localparam int MED_HI  = 7;
  localparam int MED_LO  = 4;
  localparam int LOW_HI  = 3;
  localparam int LOW_LO  = 0;

  localparam logic [11:0] SILENCE = 12'h000;

  // Cycles spent in FETCH and LOAD between the final beat of one note and
  // the first PLAY cycle of the next.
  localparam int FETCH_LAT = 2;

  function automatic logic [3:0] entry_dur(input logic [15:0] e);
    return e[DUR_HI:DUR_LO];
  endfunction

  function automatic logic [11:0] entry_note(input logic [15:0] e);
    return {e[HIGH_HI:HIGH_LO], e[MED_HI:MED_LO], e[LOW_HI:LOW_LO]};
  endfunction

endpackage

// File: rtl/note_sequencer_beat_tick_gen.sv
// Beat divider: counts CLK_HZ/BEAT_HZ cycles per beat while run is high and
// pulses tick on the terminal count. clear restarts the beat.
module beat_tick_gen
  import note_pkg::*;
#(
  parameter int CLK_HZ      = 50000000,
  parameter int BEAT_HZ     = 4,
  parameter int CLEAR_PHASE = FETCH_LAT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic clear,
  output logic tick
);

  localparam int TC = CLK_HZ / BEAT_HZ - 1;
  localparam int CW = $clog2(TC + 1);
  localparam int PH = (CLEAR_PHASE > TC) ? TC : CLEAR_PHASE;
  localparam logic [CW-1:0] TC_V = CW'(TC);
  localparam logic [CW-1:0] PH_V = CW'(PH);

  logic [CW-1:0] cnt;

  // Clearing starts the beat part-way in, so the fetch cycles that follow a
  // note's final beat are paid for out of the next note's first beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= PH_V;
    end else if (run) begin
      cnt <= (cnt == TC_V) ? '0 : cnt + 1'b1;
    end
  end

  assign tick = run && (cnt == TC_V);

endmodule

// File: rtl/note_sequencer.sv
// Score scheduler: walks the score ROM, holds each note for its beat count
// and drives the three note digits, with start/stop/pause/loop control.
module note_sequencer
  import note_pkg::*;
#(
  parameter int CLK_HZ  = 50000000,
  parameter int BEAT_HZ = 4,
  parameter int ADDR_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  input  logic              loop_en,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_en,
  input  logic [15:0]       rom_data,
  output logic [3:0]        high,
  output logic [3:0]        med,
  output logic [3:0]        low,
  output logic              note_strobe,
  output logic              busy,
  output logic              done,
  output state_t            state_dbg
);

  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [11:0]       note_q;
  logic [3:0]        beats_left;
  logic              strobe_q;
  logic              tick;
  logic              last_beat;
  logic              run;
  logic              clear;

  // Handshake: none; start/stop are single-cycle pulses sampled on clk,
  // pause/loop_en are levels, rom_data is valid the cycle after rom_en.
  assign run       = ((state == PLAY) || (state == PAUSED)) && !pause;
  assign clear     = stop || (state == LOAD);
  assign last_beat = tick && (beats_left <= 4'd1);

  beat_tick_gen #(
    .CLK_HZ (CLK_HZ),
    .BEAT_HZ(BEAT_HZ)
  ) u_beat (
    .clk  (clk),
    .rst_n(rst_n),
    .run  (run),
    .clear(clear),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (stop) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE, DONE: if (start) state_nxt = FETCH;
        FETCH:      state_nxt = LOAD;
        LOAD: begin
          if (entry_dur(rom_data) == 4'd0) state_nxt = loop_en ? FETCH : DONE;
          else                             state_nxt = PLAY;
        end
        // A resumed PAUSED cycle already counts, so it can also finish the note.
        PLAY, PAUSED: begin
          if (pause)          state_nxt = PAUSED;
          else if (last_beat) state_nxt = ((addr_q == ADDR_LAST) && !loop_en) ? DONE : FETCH;
          else                state_nxt = PLAY;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q     <= '0;
      note_q     <= SILENCE;
      beats_left <= '0;
      strobe_q   <= 1'b0;
    end else begin
      strobe_q <= 1'b0;
      if (stop) begin
        addr_q     <= '0;
        note_q     <= SILENCE;
        beats_left <= '0;
      end else begin
        case (state)
          IDLE, DONE: begin
            note_q <= SILENCE;
            if (start) addr_q <= '0;
          end
          LOAD: begin
            if (entry_dur(rom_data) == 4'd0) begin
              if (loop_en) addr_q <= '0;
            end else begin
              note_q     <= entry_note(rom_data);
              beats_left <= entry_dur(rom_data);
              strobe_q   <= 1'b1;
            end
          end
          PLAY, PAUSED: begin
            if (tick) begin
              if (beats_left > 4'd1)       beats_left <= beats_left - 4'd1;
              else if (addr_q != ADDR_LAST) addr_q    <= addr_q + 1'b1;
              else if (loop_en)             addr_q    <= '0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    rom_en           = 1'b0;
    busy             = 1'b0;
    done             = 1'b0;
    {high, med, low} = SILENCE;
    case (state)
      FETCH: begin
        rom_en           = 1'b1;
        busy             = 1'b1;
        {high, med, low} = note_q;
      end
      LOAD, PLAY: begin
        busy             = 1'b1;
        {high, med, low} = note_q;
      end
      PAUSED:  busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  assign rom_addr    = addr_q;
  assign note_strobe = strobe_q;
  assign state_dbg   = state;

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer at 10 cycles per beat and an 8-entry score.
module tb_note_sequencer;
  import note_pkg::*;

  localparam int CLK_HZ  = 40;
  localparam int BEAT_HZ = 4;
  localparam int ADDR_W  = 3;

  logic              clk      = 1'b0;
  logic              rst_n    = 1'b0;
  logic              start    = 1'b0;
  logic              stop     = 1'b0;
  logic              pause    = 1'b0;
  logic              loop_en  = 1'b0;
  logic [ADDR_W-1:0] rom_addr;
  logic              rom_en;
  logic [15:0]       rom_data = 16'h0000;
  logic [3:0]        high, med, low;
  logic              note_strobe, busy, done;
  state_t            state_dbg;

  logic [15:0] rom [8];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  logic [11:0] exp_q[$];

  typedef struct {
    string             name;
    logic              start;
    logic              stop;
    logic              pause;
    logic              loop_en;
    int                wait_cyc;
    logic [11:0]       note;
    logic              strobe;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] addr;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs[NV];

  note_sequencer #(
    .CLK_HZ (CLK_HZ),
    .BEAT_HZ(BEAT_HZ),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stop       (stop),
    .pause      (pause),
    .loop_en    (loop_en),
    .rom_addr   (rom_addr),
    .rom_en     (rom_en),
    .rom_data   (rom_data),
    .high       (high),
    .med        (med),
    .low        (low),
    .note_strobe(note_strobe),
    .busy       (busy),
    .done       (done),
    .state_dbg  (state_dbg)
  );

  // clock / ROM model
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rom_en) rom_data <= rom[rom_addr];
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver / checker tasks
  function automatic logic [11:0] cur_note();
    return {high, med, low};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic wait_strobe(input string name, input int max, output int at);
    at = -1;
    for (int k = 0; k < max; k++) begin
      step(1);
      if (note_strobe) begin
        at = cyc;
        break;
      end
    end
    chk({name, ".strobe_seen"}, 32'(at >= 0), 32'd1);
  endtask

  function automatic vec_t mk(input string nm, input logic s, input logic sp, input logic p,
                              input logic l, input int w, input logic [11:0] n, input logic st,
                              input logic b, input logic d, input logic [ADDR_W-1:0] a);
    vec_t v;
    v.name = nm; v.start = s; v.stop = sp; v.pause = p; v.loop_en = l; v.wait_cyc = w;
    v.note = n; v.strobe = st; v.busy = b; v.done = d; v.addr = a;
    return v;
  endfunction

  initial begin
    int t0, t1, tp;
    logic seen_done, early_strobe;

    for (int a = 0; a < 8; a++) rom[a] = 16'h0000;
    rom[0] = 16'h2003;
    rom[1] = 16'h1020;
    rom[2] = 16'h0000;

    vecs[0]  = mk("start_fetch",       1'b1, 1'b0, 1'b0, 1'b0, 1,  12'h000, 1'b0, 1'b1, 1'b0, 3'd0);
    vecs[1]  = mk("first_strobe",      1'b0, 1'b0, 1'b0, 1'b0, 2,  12'h003, 1'b1, 1'b1, 1'b0, 3'd0);
    vecs[2]  = mk("strobe_one_cycle",  1'b0, 1'b0, 1'b0, 1'b0, 1,  12'h003, 1'b0, 1'b1, 1'b0, 3'd0);
    vecs[3]  = mk("hold_note1",        1'b0, 1'b0, 1'b0, 1'b0, 16, 12'h003, 1'b0, 1'b1, 1'b0, 3'd0);
    vecs[4]  = mk("fetch_keeps_note",  1'b0, 1'b0, 1'b0, 1'b0, 1,  12'h003, 1'b0, 1'b1, 1'b0, 3'd1);
    vecs[5]  = mk("second_strobe",     1'b0, 1'b0, 1'b0, 1'b0, 2,  12'h020, 1'b1, 1'b1, 1'b0, 3'd1);
    vecs[6]  = mk("hold_note2",        1'b0, 1'b0, 1'b0, 1'b0, 7,  12'h020, 1'b0, 1'b1, 1'b0, 3'd1);
    vecs[7]  = mk("end_marker_done",   1'b0, 1'b0, 1'b0, 1'b0, 3,  12'h000, 1'b0, 1'b0, 1'b1, 3'd2);
    vecs[8]  = mk("done_holds",        1'b0, 1'b0, 1'b0, 1'b0, 5,  12'h000, 1'b0, 1'b0, 1'b1, 3'd2);
    vecs[9]  = mk("restart_from_done", 1'b1, 1'b0, 1'b0, 1'b0, 1,  12'h000, 1'b0, 1'b1, 1'b0, 3'd0);
    vecs[10] = mk("stop_in_fetch",     1'b0, 1'b1, 1'b0, 1'b0, 1,  12'h000, 1'b0, 1'b0, 1'b0, 3'd0);
    vecs[11] = mk("replay",            1'b1, 1'b0, 1'b0, 1'b0, 3,  12'h003, 1'b1, 1'b1, 1'b0, 3'd0);
    vecs[12] = mk("start_ignored",     1'b1, 1'b0, 1'b0, 1'b0, 3,  12'h003, 1'b0, 1'b1, 1'b0, 3'd0);
    vecs[13] = mk("stop_beats_start",  1'b1, 1'b1, 1'b0, 1'b0, 1,  12'h000, 1'b0, 1'b0, 1'b0, 3'd0);
    vecs[14] = mk("idle_stays",        1'b0, 1'b0, 1'b0, 1'b0, 4,  12'h000, 1'b0, 1'b0, 1'b0, 3'd0);
    vecs[15] = mk("pause_idle",        1'b0, 1'b0, 1'b1, 1'b0, 2,  12'h000, 1'b0, 1'b0, 1'b0, 3'd0);
    vecs[16] = mk("pause_thru_fetch",  1'b1, 1'b0, 1'b1, 1'b0, 3,  12'h003, 1'b1, 1'b1, 1'b0, 3'd0);
    vecs[17] = mk("pause_after_play",  1'b0, 1'b0, 1'b1, 1'b0, 1,  12'h000, 1'b0, 1'b1, 1'b0, 3'd0);
    vecs[18] = mk("unpause_restore",   1'b0, 1'b0, 1'b0, 1'b0, 1,  12'h003, 1'b0, 1'b1, 1'b0, 3'd0);
    vecs[19] = mk("stop_from_play",    1'b0, 1'b1, 1'b0, 1'b0, 1,  12'h000, 1'b0, 1'b0, 1'b0, 3'd0);

    // reset state
    step(1);
    chk("reset.note",   32'(cur_note()),   32'h000);
    chk("reset.busy",   32'(busy),         32'd0);
    chk("reset.done",   32'(done),         32'd0);
    chk("reset.strobe", 32'(note_strobe),  32'd0);
    chk("reset.rom_en", 32'(rom_en),       32'd0);
    chk("reset.addr",   32'(rom_addr),     32'd0);
    rst_n = 1'b1;
    step(1);

    // table-driven vectors: basic playback, restart, stop/start priority, pause gating
    for (int i = 0; i < NV; i++) begin
      start   = vecs[i].start;
      stop    = vecs[i].stop;
      pause   = vecs[i].pause;
      loop_en = vecs[i].loop_en;
      step(1);
      start = 1'b0;
      stop  = 1'b0;
      step(vecs[i].wait_cyc - 1);
      chk({vecs[i].name, ".note"},   32'(cur_note()),  32'(vecs[i].note));
      chk({vecs[i].name, ".strobe"}, 32'(note_strobe), 32'(vecs[i].strobe));
      chk({vecs[i].name, ".busy"},   32'(busy),        32'(vecs[i].busy));
      chk({vecs[i].name, ".done"},   32'(done),        32'(vecs[i].done));
      chk({vecs[i].name, ".addr"},   32'(rom_addr),    32'(vecs[i].addr));
    end

    // pause for 15 cycles in the middle of a 3-beat note
    rom[0] = 16'h3123;
    rom[1] = 16'h1456;
    rom[2] = 16'h0000;
    pulse_start();
    wait_strobe("pause.n1", 10, t0);
    chk("pause.n1_note", 32'(cur_note()), 32'h123);
    step(10);
    pause = 1'b1;
    step(1);
    chk("pause.muted_a", 32'(cur_note()), 32'h000);
    chk("pause.busy",    32'(busy),       32'd1);
    step(7);
    chk("pause.muted_b", 32'(cur_note()), 32'h000);
    step(7);
    pause = 1'b0;
    step(1);
    chk("pause.restored", 32'(cur_note()), 32'h123);
    wait_strobe("pause.n2", 60, t1);
    chk("pause.duration", 32'(t1 - t0),   32'd45);
    chk("pause.n2_note",  32'(cur_note()), 32'h456);
    stop = 1'b1;
    step(1);
    stop = 1'b0;

    // looping on an end marker
    rom[0]  = 16'h1100;
    rom[1]  = 16'h0000;
    loop_en = 1'b1;
    pulse_start();
    wait_strobe("loop.first", 10, t0);
    for (int i = 0; i < 4; i++) begin
      seen_done    = 1'b0;
      early_strobe = 1'b0;
      for (int k = 1; k <= 12; k++) begin
        step(1);
        seen_done = seen_done | done;
        if (k < 12) early_strobe = early_strobe | note_strobe;
      end
      chk($sformatf("loop.iter%0d.early", i),  32'(early_strobe), 32'd0);
      chk($sformatf("loop.iter%0d.strobe", i), 32'(note_strobe),  32'd1);
      chk($sformatf("loop.iter%0d.note", i),   32'(cur_note()),   32'h100);
      chk($sformatf("loop.iter%0d.done", i),   32'(seen_done),    32'd0);
    end
    stop    = 1'b1;
    loop_en = 1'b0;
    step(1);
    stop = 1'b0;

    // full score of 8 one-beat notes, without and then with looping
    for (int a = 0; a < 8; a++) rom[a] = {4'd1, 4'(a), 4'(a), 4'(15 - a)};
    for (int pass = 0; pass < 2; pass++) begin
      loop_en = (pass == 1);
      for (int a = 0; a < 8; a++) exp_q.push_back({4'(a), 4'(a), 4'(15 - a)});
      pulse_start();
      tp = 0;
      for (int i = 0; i < 8; i++) begin
        wait_strobe($sformatf("wrap%0d.n%0d", pass, i), 15, t1);
        if (i > 0) chk($sformatf("wrap%0d.gap%0d", pass, i), 32'(t1 - tp), 32'd10);
        chk($sformatf("wrap%0d.note%0d", pass, i), 32'(cur_note()), 32'(exp_q.pop_front()));
        tp = t1;
      end
      chk($sformatf("wrap%0d.queue_empty", pass), 32'(exp_q.size()), 32'd0);
      step(7);
      chk($sformatf("wrap%0d.last_beat_busy", pass), 32'(busy), 32'd1);
      step(1);
      if (pass == 0) begin
        chk("wrap0.done",   32'(done),   32'd1);
        chk("wrap0.rom_en", 32'(rom_en), 32'd0);
        step(3);
        chk("wrap0.no_fetch", 32'(rom_en), 32'd0);
      end else begin
        chk("wrap1.rom_en", 32'(rom_en),   32'd1);
        chk("wrap1.addr",   32'(rom_addr), 32'd0);
        chk("wrap1.done",   32'(done),     32'd0);
        step(2);
        chk("wrap1.restrobe", 32'(note_strobe), 32'd1);
        chk("wrap1.note0",    32'(cur_note()),  32'h00F);
        stop = 1'b1;
        step(1);
        stop = 1'b0;
      end
    end
    loop_en = 1'b0;

    // asynchronous reset in the middle of a note
    rom[0] = 16'h2003;
    rom[1] = 16'h1020;
    rom[2] = 16'h0000;
    pulse_start();
    wait_strobe("areset.play", 10, t0);
    step(5);
    #2 rst_n = 1'b0;
    #1;
    chk("areset.note",   32'(cur_note()),  32'h000);
    chk("areset.busy",   32'(busy),        32'd0);
    chk("areset.done",   32'(done),        32'd0);
    chk("areset.addr",   32'(rom_addr),    32'd0);
    chk("areset.strobe", 32'(note_strobe), 32'd0);
    @(negedge clk);
    step(2);
    rst_n = 1'b1;
    step(6);
    chk("areset.idle_state", 32'(state_dbg), 32'(IDLE));
    chk("areset.idle_busy",  32'(busy),      32'd0);
    chk("areset.idle_note",  32'(cur_note()), 32'h000);
    chk("areset.idle_rom",   32'(rom_en),    32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
